// File: rtl/axon_pkg.sv
// axon_pkg: shared definitions for the axon delay scheduler.
//   DEF_* constants : default widths for the neuron id and the delay counter.
//   slot_t          : record of one delay timer (valid, source id, countdown).
//   rr_pick()       : round-robin search over a request vector.
package axon_pkg;

  localparam int DEF_NUM_NEURONS = 4;
  localparam int DEF_DELAY_W     = 6;
  localparam int DEF_ID_W        = $clog2(DEF_NUM_NEURONS);

  // Widest request vector rr_pick() can search.
  localparam int RR_MAX = 64;

  typedef struct packed {
    logic                   valid;
    logic [DEF_ID_W-1:0]    id;
    logic [DEF_DELAY_W-1:0] count;
  } slot_t;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } rr_pick_t;

  // Returns the first set bit of req[n-1:0], searching upward from ptr and
  // wrapping to 0. The upper search window [ptr, n) wins over the wrapped
  // window; otherwise the lowest set bit overall is the wrapped winner.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input int ptr, input int n);
    rr_pick_t res;
    logic     found_lo;
    logic     found_hi;
    int       lo;
    int       hi;
    found_lo = 1'b0;
    found_hi = 1'b0;
    lo       = 0;
    hi       = 0;
    for (int j = RR_MAX - 1; j >= 0; j--) begin
      if (j < n && req[j]) begin
        found_lo = 1'b1;
        lo       = j;
      end
      if (j < n && j >= ptr && req[j]) begin
        found_hi = 1'b1;
        hi       = j;
      end
    end
    res.found = found_lo;
    res.idx   = found_hi ? 32'(hi) : 32'(lo);
    return res;
  endfunction

endpackage

// File: rtl/axon_delay_slot.sv
// axon_delay_slot: one shared axon delay timer.
//   clock, reset_n : clock and asynchronous active-low reset.
//   load           : capture load_id/load_delay and become valid.
//   pop            : release the slot (its spike is being emitted).
//   valid          : slot holds an in-flight spike.
//   expired        : valid and the countdown has reached 0.
//   id             : source neuron of the in-flight spike.
module axon_delay_slot
  import axon_pkg::*;
#(
  parameter int ID_W    = DEF_ID_W,
  parameter int DELAY_W = DEF_DELAY_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic [ID_W-1:0]    load_id,
  input  logic [DELAY_W-1:0] load_delay,
  input  logic               pop,
  output logic               valid,
  output logic               expired,
  output logic [ID_W-1:0]    id
);

  logic               valid_q, valid_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [DELAY_W-1:0] count_q, count_d;

  // load and pop never coincide: loads target free slots, pops valid ones.
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    count_d = count_q;
    if (load) begin
      valid_d = 1'b1;
      id_d    = load_id;
      count_d = load_delay;
    end else if (pop) begin
      valid_d = 1'b0;
    end else if (valid_q && count_q != '0) begin
      // Stops at 0 and waits there until the expiry selector picks it.
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      count_q <= count_d;
    end
  end

  assign valid   = valid_q;
  assign expired = valid_q && (count_q == '0);
  assign id      = id_q;

endmodule

// File: rtl/axon_delay_scheduler.sv
// axon_delay_scheduler: shares NUM_SLOTS axon delay timers among NUM_NEURONS
// neurons. One request per cycle is accepted round-robin into the lowest free
// slot; the lowest-index expired slot emits one tagged spike per cycle.
//   clock, reset_n : clock and asynchronous active-low reset.
//   spike_req      : per-neuron request level, held until acked.
//   delay_cfg      : per-neuron delay, neuron n at [n*DELAY_W +: DELAY_W].
//   spike_ack      : one-hot combinational accept strobe.
//   spike_out      : registered one-cycle delayed-spike pulse.
//   spike_out_id   : source neuron of spike_out, 0 when idle.
//   busy           : registered, any slot in flight.
//   full           : combinational, no slot free.
//
// Handshake: spike_req[n] is a level; the cycle in which spike_ack[n] is high
// is the transfer. The requester drops spike_req[n] in the following cycle;
// a request still high after that is a new spike. With full=1 no ack is
// given and requests simply wait, so no spike is ever dropped.
module axon_delay_scheduler
  import axon_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int NUM_SLOTS   = 4,
  parameter int DELAY_W     = DEF_DELAY_W,
  parameter int ID_W        = $clog2(NUM_NEURONS)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_NEURONS-1:0]         spike_req,
  input  logic [NUM_NEURONS*DELAY_W-1:0] delay_cfg,
  output logic [NUM_NEURONS-1:0]         spike_ack,
  output logic                           spike_out,
  output logic [ID_W-1:0]                spike_out_id,
  output logic                           busy,
  output logic                           full
);

  logic [NUM_SLOTS-1:0] slot_valid;
  logic [NUM_SLOTS-1:0] slot_expired;
  logic [NUM_SLOTS-1:0] slot_load;
  logic [NUM_SLOTS-1:0] slot_pop;
  logic [ID_W-1:0]      slot_id [NUM_SLOTS];

  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 spike_out_q, spike_out_d;
  logic [ID_W-1:0]      spike_out_id_q, spike_out_id_d;
  logic                 busy_q, busy_d;

  rr_pick_t             rr_res;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;
  logic [DELAY_W-1:0]   load_delay;

  // Full uses the current valid bits, so a slot emitting this cycle is not
  // yet available to a grant.
  assign full   = &slot_valid;
  assign rr_res = rr_pick(RR_MAX'(spike_req), int'(rr_ptr_q), NUM_NEURONS);

  // Arbiter. Ack is gated by reset_n so it is 0 while reset is asserted.
  always_comb begin
    grant_valid = rr_res.found && !full && reset_n;
    grant_id    = ID_W'(rr_res.idx);
    spike_ack   = '0;
    load_delay  = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (int'(grant_id) == n) begin
        spike_ack[n] = grant_valid;
        load_delay   = delay_cfg[n*DELAY_W +: DELAY_W];
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      rr_ptr_d = (int'(grant_id) == NUM_NEURONS - 1) ? '0 : grant_id + 1'b1;
    end
  end

  // Free-slot and expiry priority encoders. Scanning downward leaves the
  // lowest matching index as the final winner.
  always_comb begin
    slot_load = '0;
    slot_pop  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        slot_load    = '0;
        slot_load[i] = grant_valid;
      end
      if (slot_expired[i]) begin
        slot_pop    = '0;
        slot_pop[i] = 1'b1;
      end
    end
  end

  // Output registers.
  always_comb begin
    spike_out_d    = |slot_pop;
    spike_out_id_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_pop[i]) begin
        spike_out_id_d = slot_id[i];
      end
    end
    busy_d = |((slot_valid & ~slot_pop) | slot_load);
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    axon_delay_slot #(
      .ID_W    (ID_W),
      .DELAY_W (DELAY_W)
    ) u_slot (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (slot_load[gi]),
      .load_id    (grant_id),
      .load_delay (load_delay),
      .pop        (slot_pop[gi]),
      .valid      (slot_valid[gi]),
      .expired    (slot_expired[gi]),
      .id         (slot_id[gi])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q       <= '0;
      spike_out_q    <= 1'b0;
      spike_out_id_q <= '0;
      busy_q         <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      spike_out_q    <= spike_out_d;
      spike_out_id_q <= spike_out_id_d;
      busy_q         <= busy_d;
    end
  end

  assign spike_out    = spike_out_q;
  assign spike_out_id = spike_out_id_q;
  assign busy         = busy_q;

endmodule
